regfile_sb: RTL and testbench

Parametrised integer register file with N read ports, an ordered forwarding network and a pending-write scoreboard. It replaces the fixed two-read, two-forward register file between the ID stage (reads), the EX/MEM stages (forwarding) and MEM/WB (write-back). It adds a per-register scoreboard so that long-latency results (loads, and later multi-cycle ops) stall dependent reads until write-back, even after the producer has left the forwarding window.

---
 rtl/regfile_sb_pkg.sv | 16 +
 rtl/regfile_sb_rdport.sv | 69 ++++++
 rtl/regfile_sb.sv | 92 +++++++++
 tb/tb_regfile_sb.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_sb_pkg.sv
// Shared definitions for the scoreboarded register file.
package regfile_sb_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;
  localparam int unsigned AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [XLEN_DEF-1:0] reg_bus_t;
  typedef logic [AW_DEF-1:0]   reg_addr_bus_t;

  localparam logic READ_SUCCEED = 1'b1;
  localparam logic READ_FAILED  = 1'b0;

  localparam reg_bus_t ZERO_WORD = '0;

endpackage

// File: rtl/regfile_sb_rdport.sv
// One read port: reset/enable/x0 gating, ordered forwarding, write-back
// bypass, scoreboard stall, then the array value.
module regfile_sb_rdport
  import regfile_sb_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned AW    = $clog2(NREGS),
  parameter int unsigned NFWD  = 2
) (
  input  logic                 rst,
  input  logic                 en,
  input  logic [AW-1:0]        addr,
  input  logic [NFWD-1:0]      fwd_we,
  input  logic [NFWD-1:0]      fwd_rdy,
  input  logic [NFWD*AW-1:0]   fwd_waddr,
  input  logic [NFWD*XLEN-1:0] fwd_wdata,
  input  logic                 wb_we,
  input  logic [AW-1:0]        wb_waddr,
  input  logic [XLEN-1:0]      wb_wdata,
  input  logic [NREGS-1:0]     sb_busy,
  input  logic [XLEN-1:0]      arr_data,
  output logic                 ok_c,
  output logic [XLEN-1:0]      data_c
);

  logic [NFWD-1:0] hit;
  logic            hit_any;
  logic            hit_rdy;
  logic [XLEN-1:0] hit_data;

  // Address match per forwarding source
  for (genvar i = 0; i < NFWD; i++) begin : g_match
    assign hit[i] = fwd_we[i] && (fwd_waddr[i*AW +: AW] == addr);
  end

  // Pick the youngest matching source, then apply the port priority chain
  always_comb begin
    hit_any  = 1'b0;
    hit_rdy  = 1'b0;
    hit_data = '0;
    ok_c     = READ_FAILED;
    data_c   = '0;
    for (int i = int'(NFWD) - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_any  = 1'b1;
        hit_rdy  = fwd_rdy[i];
        hit_data = fwd_wdata[i*XLEN +: XLEN];
      end
    end
    if (rst || !en) begin
      ok_c = READ_FAILED;
    end else if (addr == '0) begin
      ok_c = READ_SUCCEED;
    end else if (hit_any) begin
      ok_c   = hit_rdy;
      data_c = hit_rdy ? hit_data : '0;
    end else if (wb_we && (wb_waddr == addr)) begin
      ok_c   = READ_SUCCEED;
      data_c = wb_wdata;
    end else if (sb_busy[addr]) begin
      ok_c = READ_FAILED;
    end else begin
      ok_c   = READ_SUCCEED;
      data_c = arr_data;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with NRD read ports, ordered forwarding and a pending-write
// scoreboard that stalls reads of long-latency destinations until write-back.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned AW    = $clog2(NREGS),
  parameter int unsigned NRD   = 2,
  parameter int unsigned NFWD  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wb_we,
  input  logic [AW-1:0]        wb_waddr,
  input  logic [XLEN-1:0]      wb_wdata,
  input  logic [NFWD-1:0]      fwd_we,
  input  logic [NFWD-1:0]      fwd_rdy,
  input  logic [NFWD*AW-1:0]   fwd_waddr,
  input  logic [NFWD*XLEN-1:0] fwd_wdata,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_rd,
  input  logic                 iss_long,
  input  logic                 flush,
  input  logic [NRD-1:0]       rd_en,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD-1:0]       rd_ok,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NREGS-1:0]     sb_busy
);

  logic [XLEN-1:0]  regs [NREGS-1:1];
  logic [NREGS-1:0] sb;
  logic [NREGS-1:0] sb_next;

  // Register array; x0 is not stored
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 1; r < int'(NREGS); r++) regs[r] <= '0;
    end else if (wb_we && (wb_waddr != '0)) begin
      regs[wb_waddr] <= wb_wdata;
    end
  end

  // Scoreboard next state: issue set beats write-back clear, flush beats all
  always_comb begin
    sb_next = sb;
    if (wb_we) sb_next[wb_waddr] = 1'b0;
    if (iss_valid && iss_long) sb_next[iss_rd] = 1'b1;
    sb_next[0] = 1'b0;
    if (flush) sb_next = '0;
  end

  // Scoreboard register
  always_ff @(posedge clk) begin
    if (rst) sb <= '0;
    else     sb <= sb_next;
  end

  assign sb_busy = sb;

  for (genvar p = 0; p < NRD; p++) begin : g_port
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] arr_data;

    assign addr     = rd_addr[p*AW +: AW];
    assign arr_data = (addr == '0) ? '0 : regs[addr];

    regfile_sb_rdport #(
      .XLEN  (XLEN),
      .NREGS (NREGS),
      .AW    (AW),
      .NFWD  (NFWD)
    ) u_rdport (
      .rst       (rst),
      .en        (rd_en[p]),
      .addr      (addr),
      .fwd_we    (fwd_we),
      .fwd_rdy   (fwd_rdy),
      .fwd_waddr (fwd_waddr),
      .fwd_wdata (fwd_wdata),
      .wb_we     (wb_we),
      .wb_waddr  (wb_waddr),
      .wb_wdata  (wb_wdata),
      .sb_busy   (sb),
      .arr_data  (arr_data),
      .ok_c      (rd_ok[p]),
      .data_c    (rd_data[p*XLEN +: XLEN])
    );
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus randomized
// traffic compared against an architectural model of the register file.
module tb_regfile_sb;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned NRD   = 2;
  localparam int unsigned NFWD  = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 wb_we;
  logic [AW-1:0]        wb_waddr;
  logic [XLEN-1:0]      wb_wdata;
  logic [NFWD-1:0]      fwd_we;
  logic [NFWD-1:0]      fwd_rdy;
  logic [NFWD*AW-1:0]   fwd_waddr;
  logic [NFWD*XLEN-1:0] fwd_wdata;
  logic                 iss_valid;
  logic [AW-1:0]        iss_rd;
  logic                 iss_long;
  logic                 flush;
  logic [NRD-1:0]       rd_en;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD-1:0]       rd_ok;
  logic [NRD*XLEN-1:0]  rd_data;
  logic [NREGS-1:0]     sb_busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_sb   [NREGS];

  regfile_sb #(
    .XLEN (XLEN), .NREGS (NREGS), .AW (AW), .NRD (NRD), .NFWD (NFWD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wb_we     (wb_we),
    .wb_waddr  (wb_waddr),
    .wb_wdata  (wb_wdata),
    .fwd_we    (fwd_we),
    .fwd_rdy   (fwd_rdy),
    .fwd_waddr (fwd_waddr),
    .fwd_wdata (fwd_wdata),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_long  (iss_long),
    .flush     (flush),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_ok     (rd_ok),
    .rd_data   (rd_data),
    .sb_busy   (sb_busy)
  );

  always #5 clk = ~clk;

  // Architectural read of port p from the model and the current inputs
  function automatic void exp_read(input int p, output bit ok, output logic [XLEN-1:0] d);
    logic [AW-1:0] a;
    ok = 1'b0;
    d  = '0;
    a  = rd_addr[p*AW +: AW];
    if (rst || !rd_en[p]) return;
    if (a == 0) begin ok = 1'b1; return; end
    for (int i = 0; i < int'(NFWD); i++) begin
      if (fwd_we[i] && fwd_waddr[i*AW +: AW] == a) begin
        if (fwd_rdy[i]) begin ok = 1'b1; d = fwd_wdata[i*XLEN +: XLEN]; end
        return;
      end
    end
    if (wb_we && wb_waddr == a) begin ok = 1'b1; d = wb_wdata; return; end
    if (m_sb[a]) return;
    ok = 1'b1;
    d  = m_regs[a];
  endfunction

  function automatic logic [NREGS-1:0] exp_sb();
    logic [NREGS-1:0] v;
    for (int r = 0; r < int'(NREGS); r++) v[r] = m_sb[r];
    return v;
  endfunction

  // Advance model and DUT by one clock edge using the current inputs
  task automatic tick();
    if (rst) begin
      for (int r = 0; r < int'(NREGS); r++) begin m_regs[r] = '0; m_sb[r] = 1'b0; end
    end else begin
      if (wb_we && wb_waddr != 0) m_regs[wb_waddr] = wb_wdata;
      if (flush) begin
        for (int r = 0; r < int'(NREGS); r++) m_sb[r] = 1'b0;
      end else begin
        if (wb_we) m_sb[wb_waddr] = 1'b0;
        if (iss_valid && iss_long && iss_rd != 0) m_sb[iss_rd] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;
    fwd_we = '0; fwd_rdy = '0; fwd_waddr = '0; fwd_wdata = '0;
    iss_valid = 1'b0; iss_rd = '0; iss_long = 1'b0; flush = 1'b0;
    rd_en = '0; rd_addr = '0;
  endtask

  task automatic set_reads(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_en = '1;
    rd_addr[0 +: AW]  = a0;
    rd_addr[AW +: AW] = a1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    set_reads(5'd3, 5'd0);
    #1;
    n_checks++;
    if (rd_ok !== '0 || rd_data !== '0) begin
      n_fail++;
      $display("FAIL reset_reads: ok=%b data=%h expected ok=0 data=0", rd_ok, rd_data);
    end
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (sb_busy !== '0) begin
      n_fail++;
      $display("FAIL reset_sb: sb_busy=%h expected 0", sb_busy);
    end
    for (int p = 0; p < int'(NRD); p++) begin
      n_checks++;
      if (rd_ok[p] !== 1'b1 || rd_data[p*XLEN +: XLEN] !== ((p == 0) ? 32'h0 : 32'h0)) begin
        n_fail++;
        $display("FAIL reset_array p%0d: ok=%b data=%h expected ok=1 data=0", p, rd_ok[p], rd_data[p*XLEN +: XLEN]);
      end
    end
  endtask

  task automatic test_write_read();
    idle();
    wb_we = 1'b1; wb_waddr = 5'd5; wb_wdata = 32'hDEADBEEF;
    tick();
    idle();
    set_reads(5'd5, 5'd5);
    #1;
    for (int p = 0; p < int'(NRD); p++) begin
      n_checks++;
      if (rd_ok[p] !== 1'b1 || rd_data[p*XLEN +: XLEN] !== 32'hDEADBEEF) begin
        n_fail++;
        $display("FAIL write_read x5 p%0d: ok=%b data=%h expected ok=1 data=deadbeef", p, rd_ok[p], rd_data[p*XLEN +: XLEN]);
      end
    end
    set_reads(5'd0, 5'd5);
    #1;
    n_checks++;
    if (rd_ok[0] !== 1'b1 || rd_data[XLEN-1:0] !== 32'h0) begin
      n_fail++;
      $display("FAIL read_x0: ok=%b data=%h expected ok=1 data=0", rd_ok[0], rd_data[XLEN-1:0]);
    end
    tick();
  endtask

  task automatic test_fwd_priority();
    idle();
    fwd_we = 2'b11; fwd_rdy = 2'b11;
    fwd_waddr = {5'd7, 5'd7};
    fwd_wdata = {32'h22, 32'h11};
    wb_we = 1'b1; wb_waddr = 5'd7; wb_wdata = 32'h33;
    set_reads(5'd7, 5'd7);
    #1;
    for (int p = 0; p < int'(NRD); p++) begin
      n_checks++;
      if (rd_ok[p] !== 1'b1 || rd_data[p*XLEN +: XLEN] !== 32'h11) begin
        n_fail++;
        $display("FAIL fwd_priority p%0d: ok=%b data=%h expected ok=1 data=11", p, rd_ok[p], rd_data[p*XLEN +: XLEN]);
      end
    end
    tick();
  endtask

  task automatic test_load_stall();
    idle();
    fwd_we = 2'b11; fwd_rdy = 2'b10;
    fwd_waddr = {5'd9, 5'd9};
    fwd_wdata = {32'h99, 32'h55};
    set_reads(5'd9, 5'd9);
    #1;
    for (int p = 0; p < int'(NRD); p++) begin
      n_checks++;
      if (rd_ok[p] !== 1'b0 || rd_data[p*XLEN +: XLEN] !== 32'h0) begin
        n_fail++;
        $display("FAIL load_stall p%0d: ok=%b data=%h expected ok=0 data=0", p, rd_ok[p], rd_data[p*XLEN +: XLEN]);
      end
    end
    tick();
  endtask

  task automatic test_scoreboard();
    idle();
    iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd12;
    tick();
    idle();
    set_reads(5'd12, 5'd12);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (rd_ok !== 2'b00 || rd_data !== '0) begin
        n_fail++;
        $display("FAIL sb_stall cycle%0d: ok=%b data=%h expected ok=00 data=0", c, rd_ok, rd_data);
      end
      tick();
    end
    wb_we = 1'b1; wb_waddr = 5'd12; wb_wdata = 32'h44;
    #1;
    n_checks++;
    if (rd_ok !== 2'b11 || rd_data !== {32'h44, 32'h44}) begin
      n_fail++;
      $display("FAIL sb_wb_bypass: ok=%b data=%h expected ok=11 data=44/44", rd_ok, rd_data);
    end
    tick();
    wb_we = 1'b0;
    #1;
    n_checks++;
    if (rd_ok !== 2'b11 || rd_data !== {32'h44, 32'h44} || sb_busy[12] !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_array_after_wb: ok=%b data=%h sb12=%b expected ok=11 data=44/44 sb12=0", rd_ok, rd_data, sb_busy[12]);
    end
    tick();
  endtask

  task automatic test_set_wins();
    idle();
    iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd3;
    wb_we = 1'b1; wb_waddr = 5'd3; wb_wdata = 32'h3;
    tick();
    idle();
    n_checks++;
    if (sb_busy !== 32'h0000_0008) begin
      n_fail++;
      $display("FAIL set_wins: sb_busy=%h expected 00000008", sb_busy);
    end
    flush = 1'b1;
    iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd4;
    tick();
    idle();
    n_checks++;
    if (sb_busy !== '0) begin
      n_fail++;
      $display("FAIL flush_clears: sb_busy=%h expected 0", sb_busy);
    end
    iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd0;
    tick();
    idle();
    n_checks++;
    if (sb_busy !== '0) begin
      n_fail++;
      $display("FAIL issue_x0: sb_busy=%h expected 0", sb_busy);
    end
  endtask

  task automatic test_reset_mid_stall();
    idle();
    for (int r = 1; r < int'(NREGS); r++) begin
      wb_we = 1'b1; wb_waddr = AW'(r); wb_wdata = 32'hA000_0000 + 32'(r);
      iss_valid = 1'b1; iss_long = 1'b1; iss_rd = AW'(r + 1);
      tick();
    end
    idle();
    rst = 1'b1;
    wb_we = 1'b1; wb_waddr = 5'd20; wb_wdata = 32'hBAD;
    set_reads(5'd20, 5'd0);
    #1;
    n_checks++;
    if (rd_ok !== '0 || rd_data !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_stall_reads: ok=%b data=%h expected ok=00 data=0", rd_ok, rd_data);
    end
    tick();
    idle();
    n_checks++;
    if (sb_busy !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_stall_sb: sb_busy=%h expected 0", sb_busy);
    end
    for (int r = 1; r < int'(NREGS); r += 2) begin
      set_reads(AW'(r), AW'(r + 1));
      #1;
      n_checks++;
      if (rd_ok !== 2'b11 || rd_data !== '0) begin
        n_fail++;
        $display("FAIL rst_array x%0d: ok=%b data=%h expected ok=11 data=0", r, rd_ok, rd_data);
      end
    end
    tick();
  endtask

  task automatic test_random();
    bit              eok;
    logic [XLEN-1:0] ed;
    for (int c = 0; c < 400; c++) begin
      idle();
      flush     = ($urandom_range(0, 19) == 0);
      wb_we     = $urandom_range(0, 1) == 1;
      wb_waddr  = AW'($urandom_range(0, 7));
      wb_wdata  = $urandom;
      iss_valid = $urandom_range(0, 1) == 1;
      iss_long  = $urandom_range(0, 2) != 0;
      iss_rd    = AW'($urandom_range(0, 7));
      for (int i = 0; i < int'(NFWD); i++) begin
        fwd_we[i]                = $urandom_range(0, 2) == 0;
        fwd_rdy[i]               = $urandom_range(0, 3) != 0;
        fwd_waddr[i*AW +: AW]    = AW'($urandom_range(0, 7));
        fwd_wdata[i*XLEN +: XLEN] = $urandom;
      end
      for (int p = 0; p < int'(NRD); p++) begin
        rd_en[p]             = $urandom_range(0, 7) != 0;
        rd_addr[p*AW +: AW]  = AW'($urandom_range(0, 7));
      end
      #1;
      for (int p = 0; p < int'(NRD); p++) begin
        exp_read(p, eok, ed);
        n_checks++;
        if (rd_ok[p] !== eok || rd_data[p*XLEN +: XLEN] !== ed) begin
          n_fail++;
          $display("FAIL random c%0d p%0d addr=%0d: ok=%b data=%h expected ok=%b data=%h",
                   c, p, rd_addr[p*AW +: AW], rd_ok[p], rd_data[p*XLEN +: XLEN], eok, ed);
        end
      end
      n_checks++;
      if (sb_busy !== exp_sb()) begin
        n_fail++;
        $display("FAIL random_sb c%0d: sb_busy=%h expected %h", c, sb_busy, exp_sb());
      end
      tick();
    end
  endtask

  initial begin
    for (int r = 0; r < int'(NREGS); r++) begin m_regs[r] = '0; m_sb[r] = 1'b0; end
    idle();
    @(posedge clk);
    #1;
    test_reset();
    test_write_read();
    test_fwd_priority();
    test_load_stall();
    test_scoreboard();
    test_set_wins();
    test_random();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
